// File: rtl/multdiv_unit.sv
`default_nettype none
// ============================================================================
//  Module   : multdiv_unit
//  Brief    : Iterative signed multiply / divide unit. Multiply is one
//             shift-add step per cycle on operand magnitudes. Divide is one
//             restoring step per cycle on operand magnitudes. Sign
//             correction and exception detection happen on the final step
//             edge.
//  Revision : 1.0 - initial release
// ============================================================================
module multdiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);

    localparam int             c_CW   = $clog2(WIDTH + 1);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Shared working register.
    // Multiply: {partial product high half, remaining multiplier bits}.
    // Divide:   {partial remainder, dividend bits shifting into quotient}.
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opb;     // multiplicand or divisor magnitude
    logic               r_neg;     // result must be negated
    logic               r_divz;    // divisor was zero
    logic [c_CW-1:0]    r_cnt;
    logic [WIDTH-1:0]   r_result;
    logic               r_exc;

    logic               w_start;
    logic               w_last;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;

    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH:0]     w_prod_hi;
    logic               w_mul_exc;

    logic [WIDTH:0]     w_div_shift;
    logic [WIDTH:0]     w_div_sub;
    logic [2*WIDTH-1:0] w_div_next;
    logic [WIDTH-1:0]   w_quot_mag;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_div_res;
    logic               w_div_exc;

    // A start pulse in any state restarts the unit; multiply wins a tie.
    assign w_start = ctrl_MULT | ctrl_DIV;
    assign w_last  = (r_cnt == c_LAST);

    // Magnitudes; the most-negative value maps to 2^(WIDTH-1) unsigned.
    assign w_mag_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign w_mag_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

    // Shift-add step: conditionally add multiplicand to the high half,
    // then shift the whole accumulator right, carry included.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                      + (r_acc[0] ? {1'b0, r_opb} : {(WIDTH+1){1'b0}});
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};
    assign w_prod     = r_neg ? -w_mul_next : w_mul_next;
    assign w_prod_hi  = w_prod[2*WIDTH-1:WIDTH-1];
    // Product fits only if the upper WIDTH+1 bits are a pure sign extension.
    assign w_mul_exc  = ~((&w_prod_hi) | ~(|w_prod_hi));

    // Restoring step: shift next dividend bit into the remainder, subtract
    // divisor, keep the difference when no borrow occurred.
    assign w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_div_sub   = w_div_shift - {1'b0, r_opb};
    assign w_div_next  = w_div_sub[WIDTH]
                       ? {w_div_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                       : {w_div_sub[WIDTH-1:0],   r_acc[WIDTH-2:0], 1'b1};
    assign w_quot_mag  = w_div_next[WIDTH-1:0];
    assign w_quot      = r_neg ? -w_quot_mag : w_quot_mag;
    // A positive quotient with the top bit set only arises from MIN / -1.
    assign w_div_exc   = r_divz | (~r_neg & w_quot_mag[WIDTH-1]);
    assign w_div_res   = r_divz ? {WIDTH{1'b0}} : w_quot;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: start pulses override everything, steps run to DONE.
    always_comb begin
        w_state_next = r_state;
        if (w_start) begin
            w_state_next = ctrl_MULT ? MULT : DIV;
        end else begin
            case (r_state)
                MULT:    if (w_last) w_state_next = DONE;
                DIV:     if (w_last) w_state_next = DONE;
                DONE:    w_state_next = IDLE;
                default: w_state_next = IDLE;
            endcase
        end
    end

    // Datapath: latch operands on start, iterate, publish on the last step.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_acc    <= '0;
            r_opb    <= '0;
            r_neg    <= 1'b0;
            r_divz   <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
            r_exc    <= 1'b0;
        end else if (w_start) begin
            r_cnt  <= '0;
            r_neg  <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            r_divz <= (data_operandB == '0);
            if (ctrl_MULT) begin
                r_acc <= {{WIDTH{1'b0}}, w_mag_b};
                r_opb <= w_mag_a;
            end else begin
                r_acc <= {{WIDTH{1'b0}}, w_mag_a};
                r_opb <= w_mag_b;
            end
        end else if (r_state == MULT) begin
            r_acc <= w_mul_next;
            r_cnt <= r_cnt + c_CW'(1);
            if (w_last) begin
                r_result <= w_prod[WIDTH-1:0];
                r_exc    <= w_mul_exc;
            end
        end else if (r_state == DIV) begin
            r_acc <= w_div_next;
            r_cnt <= r_cnt + c_CW'(1);
            if (w_last) begin
                r_result <= w_div_res;
                r_exc    <= w_div_exc;
            end
        end
    end

    assign data_result    = r_result;
    assign data_exception = r_exc;
    assign data_resultRDY = (r_state == DONE);

endmodule
`default_nettype wire
